mux_sel_arbiter: RTL

Round-robin arbiter that drives the 2-bit select of the 4:1 data mux. It sits directly upstream of that mux. Four sources raise requests; the arbiter picks one fairly and holds sel steady for the whole transfer. It inserts a one-cycle dead gap between grants so the mux output never switches mid-transfer. A programmable hold timeout stops a stuck source from starving the others.

---
 rtl/mux_sel_arbiter_if.sv | 28 ++
 rtl/mux_sel_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between the four requesters, the arbiter and the 4:1 mux.
// master: arbiter side (drives sel/grant/busy/timeout); slave: requester side.
interface mux_sel_arbiter_if;
  logic [3:0] req_i;
  logic       release_i;
  logic [1:0] sel_o;
  logic [3:0] grant_o;
  logic       busy_o;
  logic       timeout_o;

  modport master (
    input  req_i,
    input  release_i,
    output sel_o,
    output grant_o,
    output busy_o,
    output timeout_o
  );

  modport slave (
    output req_i,
    output release_i,
    input  sel_o,
    input  grant_o,
    input  busy_o,
    input  timeout_o
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 data mux.
// Ports: clk, rst (async high), bus (req_i, release_i -> sel_o, grant_o, busy_o, timeout_o).
module mux_sel_arbiter #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux_sel_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam bit HOLD_EN = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;

  logic [1:0] pick;
  logic [1:0] cand;
  logic       found;

  // Search last+1 .. last+4 (mod 4); the previous winner is checked last.
  always_comb begin
    pick  = last_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && bus.req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_GAP: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (found) begin
          sel_d   = pick;
          grant_d = 4'b0001 << pick;
          busy_d  = 1'b1;
          cnt_d   = '0;
          last_d  = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (bus.release_i || !bus.req_i[sel_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = S_GAP;
        end else if (HOLD_EN && cnt_q == CNT_LAST) begin
          grant_d = '0;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_GAP;
        end else if (cnt_q != '1) begin
          // saturates only when the timeout is disabled
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign bus.sel_o     = sel_q;
  assign bus.grant_o   = grant_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = tmo_q;

endmodule
